mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have these ports, one per line:
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- mult_start  input  1  one-cycle request from the control unit: signed multiply a*b
- div_start  input  1  one-cycle request from the control unit: signed divide a/b
- a  input  32  operand rs (multiplicand / dividend)
- b  input  32  operand rt (multiplier / divisor)
- hi  output  32  HI register: product[63:32] / remainder
- lo  output  32  LO register: product[31:0] / quotient
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when an operation completes
- div0  output  1  divide-by-zero flag to the control unit

Function
REQ-002 The block SHALL implement an FSM with states IDLE, MULT, DIV and DONE.
REQ-003 In IDLE, on the rising edge where mult_start=1, the block SHALL latch a and b, clear the iteration counter and enter MULT.
REQ-004 In IDLE, on the rising edge where div_start=1 and mult_start=0, the block SHALL latch a and b, clear the iteration counter and enter DIV.
REQ-005 When mult_start and div_start are both 1 in IDLE, multiply SHALL take priority.
REQ-006 Start requests that arrive in MULT, DIV or DONE SHALL be ignored and SHALL NOT be queued.
REQ-007 MULT SHALL perform a 32-iteration radix-2 Booth signed multiply, one iteration per clock, so that {hi,lo} equals the signed 64-bit product a*b.
REQ-008 DIV SHALL perform a 32-iteration restoring division on operand magnitudes, one iteration per clock, followed by sign correction:
- quotient truncates toward zero;
- remainder takes the sign of the dividend.
REQ-009 For a division, lo SHALL receive the quotient and hi SHALL receive the remainder.
REQ-010 The division 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0, with no flag raised.
REQ-011 Latency: if the start is sampled at edge N, iterations SHALL occur on edges N+1..N+32.
REQ-012 At edge N+32, hi and lo SHALL be updated and the state SHALL become DONE; done SHALL be 1 for exactly the cycle between edges N+32 and N+33, after which the state SHALL return to IDLE.
REQ-013 busy SHALL be 1 exactly while the state is MULT or DIV.
REQ-014 hi and lo SHALL change only at completion and SHALL hold their values otherwise, including during an operation.
REQ-015 A divide request with b=0 SHALL skip DIV and go directly from IDLE to DONE at the start edge, setting div0=1 and leaving hi and lo unchanged.
REQ-016 div0 SHALL remain set until the next accepted start, which SHALL clear it.
REQ-017 A successful division or any multiply SHALL leave div0=0.
REQ-018 Operand changes on a and b after the start edge SHALL NOT affect the result.

Reset
REQ-019 reset=1 SHALL immediately force the state to IDLE and set hi=0, lo=0, busy=0, done=0, div0=0, and clear the counter and all internal registers.
REQ-020 A reset asserted mid-operation SHALL abort the operation and produce no done pulse.
REQ-021 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-022 With macro MDU_FAST_MULT_EN defined:
- MULT SHALL compute the 64-bit signed product in a single cycle;
- hi and lo SHALL update at edge N+1;
- done SHALL pulse between edges N+1 and N+2;
- busy SHALL be high for one cycle.
REQ-023 With MDU_FAST_MULT_EN undefined, MULT SHALL use the 32-cycle Booth sequence of REQ-007 and REQ-011.
REQ-024 Division behaviour SHALL be identical with and without MDU_FAST_MULT_EN.

Verification
REQ-025 Multiply: a=0xFFFFFFFD (-3), b=7 with mult_start pulse -> after 32 busy cycles, done pulses with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-026 Divide: a=0xFFFFFFF9 (-7), b=2 with div_start pulse -> after 32 busy cycles, done pulses with lo=0xFFFFFFFD, hi=0xFFFFFFFF, div0=0.
REQ-027 Divide by zero: a=5, b=0 with div_start pulse -> done at the next cycle, div0=1, hi and lo unchanged; a subsequent mult_start with a=2, b=3 -> div0=0, lo=6, hi=0.
REQ-028 Simultaneous/busy starts: mult_start and div_start both pulsed with a=6, b=3 -> multiply result lo=18; a div_start at busy cycle 10 -> ignored, exactly one done pulse.
REQ-029 Reset mid-operation: reset asserted at busy cycle 15 of a 0x7FFFFFFF*0x7FFFFFFF multiply -> busy=0, hi=0, lo=0 immediately, and no done pulse follows.
REQ-030 Boundary: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; the same bench rerun with MDU_FAST_MULT_EN defined -> multiply done 1 cycle after start.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : sequential signed multiply (radix-2 Booth) / divide (restoring)
//                 with HI/LO result registers; MDU_FAST_MULT_EN -> 1-cycle multiply
// Revision      : 1.0
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  count;
    logic [32:0] acc;     // Booth partial product / division remainder
    logic [31:0] qreg;    // multiplier / dividend-then-quotient
    logic        q_1;
    logic [31:0] mcand;   // multiplicand / divisor magnitude
    logic        neg_q;
    logic        neg_r;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    assign mag_a = a[31] ? (~a + 32'd1) : a;
    assign mag_b = b[31] ? (~b + 32'd1) : b;

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    logic [32:0] div_shift;
    logic [32:0] div_sub;
    logic        div_fit;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    assign div_shift = {acc[31:0], qreg[31]};
    assign div_sub   = div_shift - {1'b0, mcand};
    assign div_fit   = (div_shift >= {1'b0, mcand});
    assign div_rem   = div_fit ? div_sub[31:0] : div_shift[31:0];
    assign div_quo   = {qreg[30:0], div_fit};

`ifdef MDU_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign fast_prod = $signed({{32{mcand[31]}}, mcand}) * $signed({{32{qreg[31]}}, qreg});
`else
    logic [32:0] booth_sum;
    always_comb begin
        booth_sum = acc;
        case ({qreg[0], q_1})
            2'b01:   booth_sum = acc + {mcand[31], mcand};
            2'b10:   booth_sum = acc - {mcand[31], mcand};
            default: booth_sum = acc;
        endcase
    end
`endif

    assign busy = (state == MULT) || (state == DIV);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 6'd0;
            acc   <= 33'd0;
            qreg  <= 32'd0;
            q_1   <= 1'b0;
            mcand <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            div0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_start) begin
                        state <= MULT;
                        count <= 6'd0;
                        div0  <= 1'b0;
                        acc   <= 33'd0;
                        qreg  <= b;
                        q_1   <= 1'b0;
                        mcand <= a;
                    end else if (div_start) begin
                        count <= 6'd0;
                        if (b == 32'd0) begin
                            div0  <= 1'b1;
                            state <= DONE;
                        end else begin
                            div0  <= 1'b0;
                            state <= DIV;
                            acc   <= 33'd0;
                            qreg  <= mag_a;
                            mcand <= mag_b;
                            neg_q <= a[31] ^ b[31];
                            neg_r <= a[31];
                        end
                    end
                end
                MULT: begin
`ifdef MDU_FAST_MULT_EN
                    hi    <= fast_prod[63:32];
                    lo    <= fast_prod[31:0];
                    state <= DONE;
`else
                    acc   <= {booth_sum[32], booth_sum[32:1]};
                    qreg  <= {booth_sum[0], qreg[31:1]};
                    q_1   <= qreg[0];
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        hi    <= booth_sum[32:1];
                        lo    <= {booth_sum[0], qreg[31:1]};
                        state <= DONE;
                    end
`endif
                end
                DIV: begin
                    acc   <= {1'b0, div_rem};
                    qreg  <= div_quo;
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        // Quotient truncates toward zero; remainder follows the dividend
                        lo    <= neg_q ? (~div_quo + 32'd1) : div_quo;
                        hi    <= neg_r ? (~div_rem + 32'd1) : div_rem;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// Self-checking bench for mult_div_unit: directed corner cases plus random
// multiplies/divides compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi   = 32'd0;
    logic [31:0] exp_lo   = 32'd0;
    logic        exp_div0 = 1'b0;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div0       (div0)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic count_dones(input int n, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_val(tag, seen, 0);
    endtask

    // mul/both select the request; inject pulses a div_start at busy cycle 10
    task automatic run_op(input bit mul, input bit both, input logic [31:0] x,
                          input logic [31:0] y, input bit inject);
        int          cycles;
        int          guard;
        int          lat;
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] prod;
        logic [31:0] old_hi;
        logic [31:0] old_lo;

        old_hi = exp_hi;
        old_lo = exp_lo;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (mul || both) begin
            prod     = sx * sy;
            exp_hi   = prod[63:32];
            exp_lo   = prod[31:0];
            exp_div0 = 1'b0;
            lat      = MUL_LAT;
        end else if (y == 32'd0) begin
            exp_div0 = 1'b1;
            lat      = 0;
        end else begin
            q        = sx / sy;
            r        = sx % sy;
            exp_lo   = q[31:0];
            exp_hi   = r[31:0];
            exp_div0 = 1'b0;
            lat      = 32;
        end

        @(negedge clk);
        a          = x;
        b          = y;
        mult_start = mul | both;
        div_start  = ~mul | both;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = $urandom;
        b          = $urandom;

        cycles = 0;
        guard  = 0;
        while (!done && guard < 100) begin
            if (busy) cycles++;
            if (busy && cycles == 5) begin
                check_val("hold_hi", hi, old_hi);
                check_val("hold_lo", lo, old_lo);
            end
            div_start = inject && busy && (cycles == 10);
            if (div_start) b = 32'd0;
            guard++;
            @(negedge clk);
        end
        div_start = 1'b0;
        check_val("latency", cycles, lat);
        check_val("done", done, 1);
        check_val("hi", hi, exp_hi);
        check_val("lo", lo, exp_lo);
        check_val("div0", div0, exp_div0);
        @(negedge clk);
        check_val("done_width", {done, busy}, 2'b00);
        if (inject) count_dones(40, "extra_done");
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        a          = 32'h7FFF_FFFF;
        b          = 32'h7FFF_FFFF;
        mult_start = 1'b1;
        @(negedge clk);
        mult_start = 1'b0;
        for (int i = 1; i < 15 && busy; i++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        @(negedge clk);
        reset    = 1'b0;
        exp_hi   = 32'd0;
        exp_lo   = 32'd0;
        exp_div0 = 1'b0;
        count_dones(40, "done_after_reset");
    endtask

    initial begin
        bit          mul;
        logic [31:0] x;
        logic [31:0] y;

        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = 32'd0;
        b          = 32'd0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", {hi, lo, busy, done, div0}, 67'd0);
        reset = 1'b0;

        run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b0, 1'b0, 32'd5, 32'd0, 1'b0);
        run_op(1'b1, 1'b0, 32'd2, 32'd3, 1'b0);
        run_op(1'b0, 1'b1, 32'd6, 32'd3, 1'b1);
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        reset_mid_op();

        for (int n = 0; n < 30; n++) begin
            mul = 1'($urandom_range(0, 1));
            x   = $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 9));
                2:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
                default: y = $urandom;
            endcase
            run_op(mul, 1'b0, x, y, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
